irq_priority_arbiter: RTL and testbench

IRQ_PRIORITY_ARBITER -- requirements
Module: irq_priority_arbiter

---
 rtl/irq_priority_arbiter.sv | 164 ++++++++++++++++
 tb/tb_irq_priority_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_arbiter.sv
// Four-source interrupt controller: edge-latched pending bits, programmable
// 2-bit priorities with round-robin tie-break, and a REQ/ACK/EOI handshake.
module irq_priority_arbiter (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_WEnable,
  input  logic [31:0] i_WAddr,
  input  logic [31:0] i_WData,
  input  logic        i_REnable,
  input  logic [31:0] i_RAddr,
  output logic [31:0] o_RData,
  output logic        o_Err,
  input  logic [3:0]  i_Irq,
  input  logic        i_Ack,
  input  logic        i_Eoi,
  output logic        o_IrqReq,
  output logic [1:0]  o_IrqId,
  output logic        o_Busy
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_REQ     = 2'd1;
  localparam logic [1:0]  ST_SERVICE = 2'd2;
  localparam logic [31:0] ADDR_CTRL  = 32'h0000_0000;
  localparam logic [31:0] ADDR_PRIO  = 32'h0000_0001;
  localparam logic [31:0] ADDR_PEND  = 32'h0000_0002;
  localparam logic [31:0] ADDR_STAT  = 32'h0000_0003;

  logic        r_Ge;
  logic [3:0]  r_En;
  logic [7:0]  r_Prio;
  logic [3:0]  r_Pend;
  logic [3:0]  r_IrqPrev;
  logic [31:0] r_RData;
  logic        r_Err;
  logic        r_IrqReq;
  logic [1:0]  r_IrqId;
  logic        r_Busy;
  logic [1:0]  r_State;
  logic [1:0]  r_LastId;

  logic        w_WLegal, w_RLegal, w_WrCtrl, w_WrPrio, w_WrPend, w_RdDo, w_ErrNext;
  logic        w_GeNext, w_AckDo, w_Any, w_Found;
  logic [3:0]  w_EnNext, w_Edge, w_PendClr, w_PendNext, w_Cand;
  logic [1:0]  w_MaxPrio, w_Winner, w_Idx, w_StateNext, w_IrqIdNext, w_LastIdNext;
  logic        w_IrqReqNext, w_BusyNext;
  logic [31:0] w_RMux;
  logic        w_unused_wdata;

  assign w_unused_wdata = ^i_WData[31:8];

  assign w_WLegal  = (i_WAddr < 32'd4);
  assign w_RLegal  = (i_RAddr < 32'd4);
  assign w_WrCtrl  = i_WEnable && (i_WAddr == ADDR_CTRL);
  assign w_WrPrio  = i_WEnable && (i_WAddr == ADDR_PRIO);
  assign w_WrPend  = i_WEnable && (i_WAddr == ADDR_PEND);
  // A write wins over a simultaneous read, so the read neither loads data nor flags an error.
  assign w_RdDo    = i_REnable && !i_WEnable && w_RLegal;
  assign w_ErrNext = i_WEnable ? !w_WLegal : (i_REnable && !w_RLegal);

  assign w_GeNext  = w_WrCtrl ? i_WData[0]   : r_Ge;
  assign w_EnNext  = w_WrCtrl ? i_WData[7:4] : r_En;

  assign w_Edge     = i_Irq & ~r_IrqPrev;
  assign w_AckDo    = (r_State == ST_REQ) && i_Ack;
  assign w_PendClr  = (w_WrPend ? i_WData[3:0] : 4'b0000) | (w_AckDo ? (4'b0001 << r_IrqId) : 4'b0000);
  assign w_PendNext = (r_Pend & ~w_PendClr) | w_Edge;

  // Arbitration: highest priority among candidates, ties resolved from last serviced ID + 1.
  always_comb begin
    w_Cand    = r_Ge ? (r_Pend & r_En) : 4'b0000;
    w_Any     = |w_Cand;
    w_MaxPrio = 2'd0;
    w_Winner  = 2'd0;
    w_Found   = 1'b0;
    w_Idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_MaxPrio = (w_Cand[k] && (r_Prio[2*k +: 2] > w_MaxPrio)) ? r_Prio[2*k +: 2] : w_MaxPrio;
    end
    for (int i = 0; i < 4; i++) begin
      w_Idx    = r_LastId + 2'd1 + 2'(i);
      w_Winner = (!w_Found && w_Cand[w_Idx] && (r_Prio[{w_Idx, 1'b0} +: 2] == w_MaxPrio)) ? w_Idx : w_Winner;
      w_Found  = w_Found || (w_Cand[w_Idx] && (r_Prio[{w_Idx, 1'b0} +: 2] == w_MaxPrio));
    end
  end

  // Next-state logic; the enable check in REQ uses the post-write CTRL so a disable drops the request at once.
  always_comb begin
    w_StateNext = r_State;
    case (r_State)
      ST_IDLE: begin
        if (w_Any) w_StateNext = ST_REQ;
        else       w_StateNext = ST_IDLE;
      end
      ST_REQ: begin
        if (i_Ack)                               w_StateNext = ST_SERVICE;
        else if (!w_GeNext || !w_EnNext[r_IrqId]) w_StateNext = ST_IDLE;
        else                                     w_StateNext = ST_REQ;
      end
      ST_SERVICE: begin
        if (i_Eoi) w_StateNext = ST_IDLE;
        else       w_StateNext = ST_SERVICE;
      end
      default: w_StateNext = ST_IDLE;
    endcase
  end

  // Output logic feeding the registered handshake outputs.
  always_comb begin
    w_IrqReqNext = (w_StateNext == ST_REQ);
    w_BusyNext   = (w_StateNext == ST_SERVICE);
    w_IrqIdNext  = ((r_State == ST_IDLE) && w_Any) ? w_Winner : r_IrqId;
    w_LastIdNext = ((r_State == ST_SERVICE) && i_Eoi) ? r_IrqId : r_LastId;
  end

  // Register read multiplexer.
  always_comb begin
    case (i_RAddr)
      ADDR_CTRL: w_RMux = {24'd0, r_En, 3'd0, r_Ge};
      ADDR_PRIO: w_RMux = {24'd0, r_Prio};
      ADDR_PEND: w_RMux = {28'd0, r_Pend};
      ADDR_STAT: w_RMux = {26'd0, r_State, 1'b0, r_Busy, r_IrqId};
      default:   w_RMux = 32'd0;
    endcase
  end

  // State register and all architectural registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Ge      <= 1'b0;
      r_En      <= 4'd0;
      r_Prio    <= 8'd0;
      r_Pend    <= 4'd0;
      r_IrqPrev <= 4'd0;
      r_RData   <= 32'd0;
      r_Err     <= 1'b0;
      r_IrqReq  <= 1'b0;
      r_IrqId   <= 2'd0;
      r_Busy    <= 1'b0;
      r_State   <= ST_IDLE;
      r_LastId  <= 2'd3;
    end else begin
      r_Ge      <= w_GeNext;
      r_En      <= w_EnNext;
      r_Prio    <= w_WrPrio ? i_WData[7:0] : r_Prio;
      r_Pend    <= w_PendNext;
      r_IrqPrev <= i_Irq;
      r_RData   <= w_RdDo ? w_RMux : r_RData;
      r_Err     <= w_ErrNext;
      r_IrqReq  <= w_IrqReqNext;
      r_IrqId   <= w_IrqIdNext;
      r_Busy    <= w_BusyNext;
      r_State   <= w_StateNext;
      r_LastId  <= w_LastIdNext;
    end
  end

  assign o_RData  = r_RData;
  assign o_Err    = r_Err;
  assign o_IrqReq = r_IrqReq;
  assign o_IrqId  = r_IrqId;
  assign o_Busy   = r_Busy;

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Directed bench for irq_priority_arbiter: each task drives one scenario and
// checks hand-computed values 1 time unit after the rising edge.
module tb_irq_priority_arbiter;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_WEnable = 1'b0;
  logic [31:0] i_WAddr = 32'd0;
  logic [31:0] i_WData = 32'd0;
  logic        i_REnable = 1'b0;
  logic [31:0] i_RAddr = 32'd0;
  logic [31:0] o_RData;
  logic        o_Err;
  logic [3:0]  i_Irq = 4'd0;
  logic        i_Ack = 1'b0;
  logic        i_Eoi = 1'b0;
  logic        o_IrqReq;
  logic [1:0]  o_IrqId;
  logic        o_Busy;

  int tests  = 0;
  int failed = 0;

  irq_priority_arbiter dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_WEnable(i_WEnable), .i_WAddr(i_WAddr), .i_WData(i_WData),
    .i_REnable(i_REnable), .i_RAddr(i_RAddr), .o_RData(o_RData), .o_Err(o_Err),
    .i_Irq(i_Irq), .i_Ack(i_Ack), .i_Eoi(i_Eoi),
    .o_IrqReq(o_IrqReq), .o_IrqId(o_IrqId), .o_Busy(o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    i_WEnable = 1'b1; i_WAddr = a; i_WData = d;
    tick();
    i_WEnable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    i_REnable = 1'b1; i_RAddr = a;
    tick();
    i_REnable = 1'b0;
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    i_Irq = v;
    tick();
    i_Irq = 4'd0;
  endtask

  task automatic ack();
    i_Ack = 1'b1; tick(); i_Ack = 1'b0;
  endtask

  task automatic eoi();
    i_Eoi = 1'b1; tick(); i_Eoi = 1'b0;
  endtask

  task automatic test_reset();
    i_Rst = 1'b1; tick(); tick();
    tests++; if ({o_IrqReq, o_IrqId, o_Busy, o_Err} !== 5'b0) begin failed++; $display("FAIL reset_outs: got %b expected 00000", {o_IrqReq, o_IrqId, o_Busy, o_Err}); end
    tests++; if (o_RData !== 32'd0) begin failed++; $display("FAIL reset_rdata: got %h expected 0", o_RData); end
    i_Rst = 1'b0;
    rd(32'h0);
    tests++; if (o_RData !== 32'd0) begin failed++; $display("FAIL reset_ctrl: got %h expected 0", o_RData); end
    rd(32'h3);
    tests++; if (o_RData !== 32'd0) begin failed++; $display("FAIL reset_status: got %h expected 0", o_RData); end
  endtask

  task automatic test_basic();
    wr(32'h0, 32'hF1);
    wr(32'h1, 32'h00);
    ack();
    tests++; if (o_Busy !== 1'b0) begin failed++; $display("FAIL ack_in_idle: busy got %b expected 0", o_Busy); end
    pulse_irq(4'b0101);
    tests++; if (o_IrqReq !== 1'b0) begin failed++; $display("FAIL latency_early: req got %b expected 0", o_IrqReq); end
    tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd0) begin failed++; $display("FAIL basic_first: req/id got %b/%0d expected 1/0", o_IrqReq, o_IrqId); end
    ack();
    tests++; if (o_IrqReq !== 1'b0 || o_Busy !== 1'b1) begin failed++; $display("FAIL basic_ack: req/busy got %b/%b expected 0/1", o_IrqReq, o_Busy); end
    rd(32'h3);
    tests++; if (o_RData !== 32'h24) begin failed++; $display("FAIL basic_status: got %h expected 24", o_RData); end
    rd(32'h2);
    tests++; if (o_RData !== 32'h4) begin failed++; $display("FAIL basic_pend: got %h expected 4", o_RData); end
    eoi();
    tests++; if (o_Busy !== 1'b0 || o_IrqReq !== 1'b0) begin failed++; $display("FAIL basic_eoi: busy/req got %b/%b expected 0/0", o_Busy, o_IrqReq); end
    tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd2) begin failed++; $display("FAIL basic_second: req/id got %b/%0d expected 1/2", o_IrqReq, o_IrqId); end
    ack(); eoi();
  endtask

  task automatic test_priority();
    wr(32'h1, 32'hC0);
    pulse_irq(4'b1010);
    tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd3) begin failed++; $display("FAIL prio_first: req/id got %b/%0d expected 1/3", o_IrqReq, o_IrqId); end
    ack(); eoi(); tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd1) begin failed++; $display("FAIL prio_second: req/id got %b/%0d expected 1/1", o_IrqReq, o_IrqId); end
    ack(); eoi();
  endtask

  task automatic test_no_preempt();
    pulse_irq(4'b0010);
    tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd1) begin failed++; $display("FAIL nopre_req: req/id got %b/%0d expected 1/1", o_IrqReq, o_IrqId); end
    pulse_irq(4'b1000);
    tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd1) begin failed++; $display("FAIL nopre_hold: req/id got %b/%0d expected 1/1", o_IrqReq, o_IrqId); end
    ack();
    tests++; if (o_Busy !== 1'b1 || o_IrqId !== 2'd1) begin failed++; $display("FAIL nopre_ack: busy/id got %b/%0d expected 1/1", o_Busy, o_IrqId); end
    eoi(); tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd3) begin failed++; $display("FAIL nopre_after: req/id got %b/%0d expected 1/3", o_IrqReq, o_IrqId); end
    ack(); eoi();
  endtask

  task automatic test_round_robin();
    wr(32'h1, 32'h00);
    pulse_irq(4'b0110);
    tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd1) begin failed++; $display("FAIL rr_a: req/id got %b/%0d expected 1/1", o_IrqReq, o_IrqId); end
    eoi();
    tests++; if (o_IrqReq !== 1'b1 || o_Busy !== 1'b0) begin failed++; $display("FAIL eoi_in_req: req/busy got %b/%b expected 1/0", o_IrqReq, o_Busy); end
    ack(); eoi(); tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd2) begin failed++; $display("FAIL rr_b: req/id got %b/%0d expected 1/2", o_IrqReq, o_IrqId); end
    ack(); eoi();
    pulse_irq(4'b1010);
    tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd3) begin failed++; $display("FAIL rr_c: req/id got %b/%0d expected 1/3", o_IrqReq, o_IrqId); end
    ack(); eoi(); tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd1) begin failed++; $display("FAIL rr_d: req/id got %b/%0d expected 1/1", o_IrqReq, o_IrqId); end
    ack(); eoi();
  endtask

  task automatic test_err();
    wr(32'h10, 32'hFF);
    tests++; if (o_Err !== 1'b1) begin failed++; $display("FAIL err_wr: got %b expected 1", o_Err); end
    rd(32'h3);
    tests++; if (o_Err !== 1'b0 || o_RData !== 32'h01) begin failed++; $display("FAIL err_status: err/rdata got %b/%h expected 0/01", o_Err, o_RData); end
    rd(32'h0);
    tests++; if (o_RData !== 32'hF1) begin failed++; $display("FAIL err_ctrl_kept: got %h expected f1", o_RData); end
    i_REnable = 1'b1; i_RAddr = 32'h10;
    wr(32'h1, 32'h00);
    i_REnable = 1'b0;
    tests++; if (o_Err !== 1'b0 || o_RData !== 32'hF1) begin failed++; $display("FAIL wr_rd_same: err/rdata got %b/%h expected 0/f1", o_Err, o_RData); end
    wr(32'h3, 32'hFF);
    tests++; if (o_Err !== 1'b0) begin failed++; $display("FAIL wr_status: err got %b expected 0", o_Err); end
    wr(32'h8000_0001, 32'h0);
    tests++; if (o_Err !== 1'b1) begin failed++; $display("FAIL err_high_addr: got %b expected 1", o_Err); end
    rd(32'hFFFF_FFFF);
    tests++; if (o_Err !== 1'b1 || o_RData !== 32'hF1) begin failed++; $display("FAIL err_rd: err/rdata got %b/%h expected 1/f1", o_Err, o_RData); end
    tick();
    tests++; if (o_Err !== 1'b0) begin failed++; $display("FAIL err_clear: got %b expected 0", o_Err); end
  endtask

  task automatic test_ctrl_drop();
    pulse_irq(4'b0001);
    tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd0) begin failed++; $display("FAIL drop_req: req/id got %b/%0d expected 1/0", o_IrqReq, o_IrqId); end
    wr(32'h0, 32'h00);
    tests++; if (o_IrqReq !== 1'b0) begin failed++; $display("FAIL drop_now: req got %b expected 0", o_IrqReq); end
    rd(32'h2);
    tests++; if (o_RData !== 32'h1) begin failed++; $display("FAIL drop_pend_kept: got %h expected 1", o_RData); end
    i_Irq = 4'b0100;
    wr(32'h2, 32'hF);
    rd(32'h2);
    tests++; if (o_RData !== 32'h4) begin failed++; $display("FAIL w1c_set_wins: got %h expected 4", o_RData); end
    wr(32'h2, 32'hF);
    rd(32'h2);
    tests++; if (o_RData !== 32'h0) begin failed++; $display("FAIL w1c_clear: got %h expected 0", o_RData); end
    i_Irq = 4'd0;
    tick();
  endtask

  task automatic test_reset_service();
    wr(32'h0, 32'hF1);
    i_Irq = 4'b0100;
    tick(); tick();
    tests++; if (o_IrqReq !== 1'b1 || o_IrqId !== 2'd2) begin failed++; $display("FAIL rs_req: req/id got %b/%0d expected 1/2", o_IrqReq, o_IrqId); end
    ack();
    tests++; if (o_Busy !== 1'b1) begin failed++; $display("FAIL rs_busy: got %b expected 1", o_Busy); end
    i_Rst = 1'b1; tick();
    tests++; if ({o_IrqReq, o_IrqId, o_Busy} !== 4'b0) begin failed++; $display("FAIL rs_abort: got %b expected 0000", {o_IrqReq, o_IrqId, o_Busy}); end
    i_Rst = 1'b0;
    rd(32'h2);
    tests++; if (o_RData !== 32'h0) begin failed++; $display("FAIL rs_pend_cleared: got %h expected 0", o_RData); end
    rd(32'h2);
    tests++; if (o_RData !== 32'h4) begin failed++; $display("FAIL rs_repend: got %h expected 4", o_RData); end
    tests++; if (o_IrqReq !== 1'b0) begin failed++; $display("FAIL rs_no_req: got %b expected 0", o_IrqReq); end
    i_Irq = 4'd0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_no_preempt();
    test_round_robin();
    test_err();
    test_ctrl_drop();
    test_reset_service();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
